// File: rtl/histogram_counter.sv
// Event histogram: one counter per input value. Every accepted value is reported
// one cycle later with its updated count. A sequential sweep zeroes all bins after
// reset or on request, and a separate read port returns any bin's count.

// One histogram bin: a count register loaded when its write enable is high.
module histogram_bin #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             we,
  input  logic [CNT_W-1:0] wdata,
  output logic [CNT_W-1:0] cnt
);

  // Count storage; the sweep also clears it, so the reset value is only for tidiness.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)   cnt <= '0;
    else if (we) cnt <= wdata;
  end

endmodule

module histogram_counter #(
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_num,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_num,
  output logic [CNT_W-1:0]  out_cnt,
  output logic              out_sat,
  input  logic              rd_req,
  input  logic [DATA_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [CNT_W-1:0]  rd_cnt,
  input  logic              clr_req,
  output logic              busy
);

  localparam int               BINS    = 1 << DATA_W;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                       state;
  logic [DATA_W-1:0]            idx;
  logic [BINS-1:0][CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]             cur;
  logic [CNT_W-1:0]             nxt;
  logic [CNT_W-1:0]             wdata;
  logic                         xfer;
  logic                         sweeping;

  assign xfer     = in_valid && in_ready;
  assign sweeping = (state == CLEAR);
  assign cur      = cnt[in_num];
  assign wdata    = sweeping ? '0 : nxt;

  // Next count for the addressed bin: increment, with saturate-or-wrap at the top.
  // Bins are flops written at the edge, so a back-to-back transfer on the same
  // value already sees the freshly written count here.
  always_comb begin
    nxt = cur + CNT_W'(1);
    if (cur == CNT_MAX && SATURATE != 0) nxt = CNT_MAX;
  end

  // Bin array: written by the sweep index during CLEAR, by in_num on a transfer.
  for (genvar g = 0; g < BINS; g++) begin : g_bin
    logic we;
    assign we = (sweeping && idx == DATA_W'(g)) || (xfer && in_num == DATA_W'(g));
    histogram_bin #(.CNT_W(CNT_W)) u_bin (
      .clk   (clk),
      .rstn  (rstn),
      .we    (we),
      .wdata (wdata),
      .cnt   (cnt[g])
    );
  end

  // Clear/run sequencer with registered busy and in_ready.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= CLEAR;
      idx      <= '0;
      busy     <= 1'b1;
      in_ready <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          idx <= idx + DATA_W'(1);
          if (idx == DATA_W'(BINS - 1)) begin
            state    <= RUN;
            busy     <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        RUN: begin
          if (clr_req) begin
            state    <= CLEAR;
            idx      <= '0;
            busy     <= 1'b1;
            in_ready <= 1'b0;
          end
        end
        default: begin
          state    <= CLEAR;
          idx      <= '0;
          busy     <= 1'b1;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

  // Update report: accepted value and its new count, held between transfers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_num   <= '0;
      out_cnt   <= '0;
      out_sat   <= 1'b0;
    end else begin
      out_valid <= xfer;
      if (xfer) begin
        out_num <= in_num;
        out_cnt <= nxt;
        out_sat <= (nxt == CNT_MAX);
      end
    end
  end

  // Read port: samples the bin before this cycle's write lands, ignored while sweeping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      rd_valid <= rd_req && !sweeping;
      if (rd_req && !sweeping) rd_cnt <= cnt[rd_addr];
    end
  end

endmodule

// File: tb/tb_histogram_counter.sv
// Randomised scoreboard bench: two instances (saturating and wrapping, 3-bit counts,
// 16 bins) share stimulus; a reference histogram predicts every report and read.
module tb_histogram_counter;

  localparam int DW   = 4;
  localparam int CW   = 3;
  localparam int BINS = 16;
  localparam int MAXC = 7;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic in_valid = 1'b0, rd_req = 1'b0, clr_req = 1'b0;
  logic [DW-1:0] in_num = '0, rd_addr = '0;

  logic s_in_ready, s_out_valid, s_out_sat, s_rd_valid, s_busy;
  logic w_in_ready, w_out_valid, w_out_sat, w_rd_valid, w_busy;
  logic [DW-1:0] s_out_num, w_out_num;
  logic [CW-1:0] s_out_cnt, w_out_cnt, s_rd_cnt, w_rd_cnt;

  histogram_counter #(.DATA_W(DW), .CNT_W(CW), .SATURATE(1)) u_sat (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_num(in_num), .in_ready(s_in_ready),
    .out_valid(s_out_valid), .out_num(s_out_num), .out_cnt(s_out_cnt), .out_sat(s_out_sat),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(s_rd_valid), .rd_cnt(s_rd_cnt),
    .clr_req(clr_req), .busy(s_busy));

  histogram_counter #(.DATA_W(DW), .CNT_W(CW), .SATURATE(0)) u_wrap (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_num(in_num), .in_ready(w_in_ready),
    .out_valid(w_out_valid), .out_num(w_out_num), .out_cnt(w_out_cnt), .out_sat(w_out_sat),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(w_rd_valid), .rd_cnt(w_rd_cnt),
    .clr_req(clr_req), .busy(w_busy));

  always #5 clk = ~clk;

  typedef struct { int num; int cs; int cw; } out_t;
  typedef struct { int cs; int cw; } rd_t;

  out_t exp_out[$];
  rd_t  exp_rd[$];

  int checks = 0, failures = 0;
  int bins_s[BINS], bins_w[BINS];
  int clear_left = BINS;
  int last_num = 0, last_s = 0, last_w = 0, last_rs = 0, last_rw = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs and advance the reference model at the clock edge.
  task automatic step(input bit v, input int n, input bit rq, input int ra, input bit clr);
    out_t o;
    rd_t  r;
    in_valid = v; in_num = DW'(n); rd_req = rq; rd_addr = DW'(ra); clr_req = clr;
    @(posedge clk);
    if (rstn) begin
      if (clear_left == 0) begin
        if (rq) begin
          r.cs = bins_s[ra]; r.cw = bins_w[ra];
          exp_rd.push_back(r);
        end
        if (v) begin
          bins_s[n] = (bins_s[n] < MAXC) ? bins_s[n] + 1 : MAXC;
          bins_w[n] = (bins_w[n] + 1) % (MAXC + 1);
          o.num = n; o.cs = bins_s[n]; o.cw = bins_w[n];
          exp_out.push_back(o);
        end
        if (clr) begin
          clear_left = BINS;
          for (int i = 0; i < BINS; i++) begin bins_s[i] = 0; bins_w[i] = 0; end
        end
      end else begin
        clear_left--;
      end
    end
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0);
  endtask

  task automatic check_reset_vals();
    chk("rst_out_valid", {s_out_valid, w_out_valid}, 0);
    chk("rst_out_num", {s_out_num, w_out_num}, 0);
    chk("rst_out_cnt", {s_out_cnt, w_out_cnt}, 0);
    chk("rst_out_sat", {s_out_sat, w_out_sat}, 0);
    chk("rst_rd_valid", {s_rd_valid, w_rd_valid}, 0);
    chk("rst_rd_cnt", {s_rd_cnt, w_rd_cnt}, 0);
    chk("rst_in_ready", {s_in_ready, w_in_ready}, 0);
    chk("rst_busy", {s_busy, w_busy}, 3);
  endtask

  task automatic model_reset();
    exp_out.delete(); exp_rd.delete();
    clear_left = BINS;
    last_num = 0; last_s = 0; last_w = 0; last_rs = 0; last_rw = 0;
    for (int i = 0; i < BINS; i++) begin bins_s[i] = 0; bins_w[i] = 0; end
  endtask

  // Monitor: compares handshake state, reports and reads against the scoreboard.
  always @(negedge clk) begin
    out_t o;
    rd_t  r;
    if (rstn) begin
      chk("in_ready_s", s_in_ready, clear_left == 0);
      chk("in_ready_w", w_in_ready, clear_left == 0);
      chk("busy_s", s_busy, clear_left != 0);
      chk("busy_w", w_busy, clear_left != 0);
      chk("out_valid_s", s_out_valid, exp_out.size() > 0);
      chk("out_valid_w", w_out_valid, exp_out.size() > 0);
      if (exp_out.size() > 0) begin
        o = exp_out.pop_front();
        last_num = o.num; last_s = o.cs; last_w = o.cw;
        chk("out_sat_s", s_out_sat, o.cs == MAXC);
        chk("out_sat_w", w_out_sat, o.cw == MAXC);
      end
      chk("out_num_s", s_out_num, last_num);
      chk("out_num_w", w_out_num, last_num);
      chk("out_cnt_s", s_out_cnt, last_s);
      chk("out_cnt_w", w_out_cnt, last_w);
      chk("rd_valid_s", s_rd_valid, exp_rd.size() > 0);
      chk("rd_valid_w", w_rd_valid, exp_rd.size() > 0);
      if (exp_rd.size() > 0) begin
        r = exp_rd.pop_front();
        last_rs = r.cs; last_rw = r.cw;
      end
      chk("rd_cnt_s", s_rd_cnt, last_rs);
      chk("rd_cnt_w", w_rd_cnt, last_rw);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    rstn = 1'b1;

    // Post-reset sweep, then every bin reads zero.
    idle(18);
    for (int a = 0; a < BINS; a++) step(0, 0, 1, a, 0);
    idle(1);

    // Back-to-back stream on one value with an interleaved other value.
    step(1, 5, 0, 0, 0); step(1, 5, 0, 0, 0); step(1, 5, 0, 0, 0);
    step(1, 7, 0, 0, 0); step(1, 5, 0, 0, 0);
    step(0, 0, 1, 5, 0); step(0, 0, 1, 7, 0);
    idle(1);

    // Nine hits on one value: saturate vs wrap.
    for (int i = 0; i < 9; i++) step(1, 9, 0, 0, 0);
    idle(1);

    // Clear together with an accepted transfer; traffic during the sweep is dropped.
    step(1, 3, 0, 0, 1);
    for (int i = 0; i < BINS + 2; i++) step($urandom_range(0, 1), $urandom_range(0, BINS - 1), 0, 0, 0);
    step(0, 0, 1, 3, 0);
    idle(1);

    // Same-cycle read and write on bin 2 holding 4.
    for (int i = 0; i < 4; i++) step(1, 2, 0, 0, 0);
    step(1, 2, 1, 2, 0);
    step(0, 0, 1, 2, 0);
    idle(1);

    // Reset in the middle of a clear sweep.
    step(0, 0, 0, 0, 1);
    idle(8);
    rstn = 1'b0;
    #1;
    check_reset_vals();
    model_reset();
    idle(2);
    rstn = 1'b1;
    idle(BINS + 2);

    // Random traffic with occasional clears.
    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1), $urandom_range(0, BINS - 1), $urandom_range(0, 1),
           $urandom_range(0, BINS - 1), $urandom_range(0, 39) == 0);
    idle(3);

    chk("out_queue_drained", exp_out.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/histogram_counter.md
# histogram_counter

Parametrised event-histogram block: counts how many times each input value has been accepted and reports the accepted value with its updated count one cycle later. Successor to the fixed 8-bit number counter, adding configurable value and count widths, a valid/ready handshake, a saturate-or-wrap policy, an independent read-out port and a sequenced bin clear. It sits on the statistics path behind any producer of small-alphabet symbols, such as opcodes, error codes or byte values.

## Interface
- DATA_W, 8: input value width; the block has 2^DATA_W bins.
- CNT_W, 16: per-bin count width.
- SATURATE, 1: 1 = bins hold at 2^CNT_W-1; 0 = bins wrap to 0.

- clk  in  1  single clock; all logic on rising edge.
- rstn  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  in_num is presented.
- in_num  in  DATA_W  value to count.
- in_ready  out  1  block accepts in_num this cycle.
- out_valid  out  1  one-cycle pulse; out_num/out_cnt valid.
- out_num  out  DATA_W  value accepted in the previous cycle.
- out_cnt  out  CNT_W  that bin's count after the update.
- out_sat  out  1  out_cnt equals 2^CNT_W-1; qualified by out_valid.
- rd_req  in  1  query a bin.
- rd_addr  in  DATA_W  bin to query.
- rd_valid  out  1  one-cycle pulse; rd_cnt valid.
- rd_cnt  out  CNT_W  queried bin count.
- clr_req  in  1  request to zero all bins.
- busy  out  1  a clear sweep is in progress.

## Operation
- Two states: CLEAR and RUN.
- CLEAR: a sweep index starts at 0. Each cycle it writes 0 to bin[idx] and then increments idx.
  - After bin 2^DATA_W-1 is written, the next state is RUN.
  - busy=1 and in_ready=0 throughout CLEAR.
- Entry into CLEAR:
  - Reset assertion forces CLEAR with idx=0. Reset in the middle of a sweep restarts it from 0.
  - clr_req sampled high in RUN also enters CLEAR.
  - clr_req during CLEAR is ignored.
- RUN: in_ready=1 and busy=0.
- Transfer: a transfer occurs when in_valid && in_ready. It performs bin[in_num] <= f(bin[in_num]), where:
  - f(x) = x+1 when x < 2^CNT_W-1.
  - At x = 2^CNT_W-1, f(x) holds at max when SATURATE=1 and wraps to 0 when SATURATE=0.
- in_valid while in_ready=0 is not a transfer. Producers hold or drop data; the block never counts it.
- Back-to-back transfers of the same value in consecutive cycles must each increment. The read-modify-write path forwards the just-written count, so no update is lost.
- out_num/out_cnt hold their last values when out_valid=0.
- Read port:
  - rd_req in RUN returns, next cycle, bin[rd_addr] including all transfers accepted up to the previous cycle. A transfer accepted in the same cycle as rd_req is not included.
  - rd_req in CLEAR is ignored; rd_valid stays 0.
- clr_req and a transfer in the same RUN cycle: the transfer is accepted and reported on out_*, then the sweep zeroes that bin.

## Timing
- Reset values: out_valid=0, out_num=0, out_cnt=0, out_sat=0, rd_valid=0, rd_cnt=0, in_ready=0, busy=1.
- After rstn deasserts, busy stays high for exactly 2^DATA_W cycles. in_ready rises on the following edge.
- Clear duration: clr_req in cycle N gives busy=1 from N+1 through N+2^DATA_W, and in_ready=1 at N+2^DATA_W+1.
- Update latency: a transfer in cycle N gives out_valid=1 in N+1 with the updated count.
- Throughput: one transfer per cycle in RUN.
- Read latency: rd_req in cycle N gives rd_valid=1 in N+1. The read port is independent of the update path.

## Test plan
- Post-reset sweep (DATA_W=4): busy=1 for 16 cycles, then in_ready=1. Afterwards, rd_req to each of the 16 bins returns rd_cnt=0.
- Stream 5,5,5,7,5 on consecutive cycles: out_cnt sequence 1,2,3,1,4 with out_num 5,5,5,7,5. Then rd_addr=5 returns 4 and rd_addr=7 returns 1.
- Saturation (CNT_W=3):
  - SATURATE=1, value 9 sent 9 times: out_cnt 1..7,7,7, with out_sat=1 on the last three.
  - SATURATE=0, same stimulus: out_cnt 1..7,0,1.
- clr_req together with in_num=3 accepted:
  - out_valid with out_cnt=1.
  - busy for 2^DATA_W cycles; in_valid during this window is not counted.
  - Afterwards, rd_addr=3 returns 0.
- Mid-sweep reset: assert rstn=0 halfway through a clr sweep. All outputs take reset values immediately. After release, a full 2^DATA_W sweep occurs.
- Same-cycle read and write on bin 2 (prior count 4): rd_cnt=4, out_cnt=5. A read on the next cycle returns 5.
